// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT sequencing controller.
package fft8_pkg;

    localparam int N_PTS = 8;
    localparam int LOG2N = 3;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] top;
        logic [2:0] bot;
    } wb_entry_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] x);
        return {x[0], x[1], x[2]};
    endfunction

endpackage

// File: rtl/fft8_seq_ctrl_if.sv
// Control bundle between the FFT sequencer (master) and the datapath/source/sink (slave).
// Handshakes: a transfer happens on a rising CLK edge where valid and ready are both high;
// valid never waits on ready, and the source holds its payload while valid is high and ready is low.
interface fft8_seq_ctrl_if;

    logic                 in_valid;
    logic                 in_ready;
    logic                 smp_wr_en;
    logic [2:0]           smp_wr_addr;
    logic                 bfly_issue;
    logic [2:0]           rd_addr_top;
    logic [2:0]           rd_addr_bot;
    logic [1:0]           tw_idx;
    logic                 wb_en;
    logic [2:0]           wb_addr_top;
    logic [2:0]           wb_addr_bot;
    logic                 bfly_scale;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           out_addr;
    logic                 busy;
    logic                 frame_done;
    fft8_pkg::state_t     dbg_state;

    modport master (
        input  in_valid, out_ready,
        output in_ready, smp_wr_en, smp_wr_addr, bfly_issue, rd_addr_top, rd_addr_bot,
               tw_idx, wb_en, wb_addr_top, wb_addr_bot, bfly_scale, out_valid, out_addr,
               busy, frame_done, dbg_state
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, smp_wr_en, smp_wr_addr, bfly_issue, rd_addr_top, rd_addr_bot,
               tw_idx, wb_en, wb_addr_top, wb_addr_bot, bfly_scale, out_valid, out_addr,
               busy, frame_done, dbg_state
    );

endinterface

// File: rtl/fft8_addr_gen.sv
// Radix-2 DIT butterfly address/twiddle map for 8 points: (stage, butterfly) -> (top, bot, k).
module fft8_addr_gen (
    input  logic [1:0] i_stage,
    input  logic [1:0] i_bfly,
    output logic [2:0] o_top,
    output logic [2:0] o_bot,
    output logic [1:0] o_tw_idx
);

    // Span doubles per stage; the twiddle exponent is the position within the span scaled to W8.
    always_comb begin
        o_top    = '0;
        o_bot    = '0;
        o_tw_idx = '0;
        case (i_stage)
            2'd0: begin
                o_top    = {i_bfly, 1'b0};
                o_bot    = {i_bfly, 1'b1};
                o_tw_idx = 2'd0;
            end
            2'd1: begin
                o_top    = {i_bfly[1], 1'b0, i_bfly[0]};
                o_bot    = {i_bfly[1], 1'b1, i_bfly[0]};
                o_tw_idx = {i_bfly[0], 1'b0};
            end
            2'd2: begin
                o_top    = {1'b0, i_bfly};
                o_bot    = {1'b1, i_bfly};
                o_tw_idx = i_bfly;
            end
            default: begin
                o_top    = '0;
                o_bot    = '0;
                o_tw_idx = '0;
            end
        endcase
    end

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Frame sequencer for the 8-point FFT: bit-reversed load, 12 butterflies, natural-order unload.
// FFT8_SEQ_CTRL_SCALE_EN: assert bfly_scale with every write-back (1/8 per frame); PIPE_LAT legal 1..7.
module fft8_seq_ctrl
    import fft8_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic           CLK,
    input  logic           RST,
    fft8_seq_ctrl_if.master bus
);

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_PTS - 1);
    localparam logic [2:0]       GAP_INIT = 3'(PIPE_LAT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LOG2N-1:0]  r_load_cnt;
    logic [LOG2N-1:0]  r_unload_cnt;
    logic [1:0]        r_stage;
    logic [1:0]        r_bfly;
    logic [2:0]        r_gap;
    logic              r_drain;
    wb_entry_t         r_pipe [PIPE_LAT];

    logic              w_load_acc;
    logic              w_unload_acc;
    logic              w_issue;
    logic [2:0]        w_top;
    logic [2:0]        w_bot;
    logic [1:0]        w_tw;
    logic [2:0]        w_rd_top;
    logic [2:0]        w_rd_bot;

    fft8_addr_gen u_addr_gen (
        .i_stage  (r_stage),
        .i_bfly   (r_bfly),
        .o_top    (w_top),
        .o_bot    (w_bot),
        .o_tw_idx (w_tw)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= LOAD;
        else     r_state <= w_state_nxt;
    end

    // in_ready is masked by RST so the port reads 0 while reset is held.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_acc     = 1'b0;
        w_unload_acc   = 1'b0;
        w_issue        = 1'b0;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.frame_done = 1'b0;
        case (r_state)
            LOAD: begin
                bus.in_ready = !RST;
                w_load_acc   = bus.in_valid && !RST;
                if (w_load_acc && r_load_cnt == CNT_LAST) w_state_nxt = COMPUTE;
            end
            COMPUTE: begin
                w_issue = (r_gap == 3'd0) && !r_drain;
                if (r_drain && r_gap == 3'd1) w_state_nxt = UNLOAD;
            end
            UNLOAD: begin
                bus.out_valid = 1'b1;
                w_unload_acc  = bus.out_ready;
                if (w_unload_acc && r_unload_cnt == CNT_LAST) begin
                    bus.frame_done = 1'b1;
                    w_state_nxt    = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // r_gap idles the issue slot after each stage so the next stage reads written-back data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_load_cnt   <= '0;
            r_unload_cnt <= '0;
            r_stage      <= '0;
            r_bfly       <= '0;
            r_gap        <= '0;
            r_drain      <= 1'b0;
        end else begin
            if (w_load_acc)   r_load_cnt   <= r_load_cnt + 1'b1;
            if (w_unload_acc) r_unload_cnt <= r_unload_cnt + 1'b1;
            if (w_issue) begin
                r_bfly <= r_bfly + 1'b1;
                if (r_bfly == 2'd3) begin
                    r_gap <= GAP_INIT;
                    if (r_stage == 2'd2) begin
                        r_drain <= 1'b1;
                        r_stage <= '0;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
            end else if (r_gap != 3'd0) begin
                r_gap <= r_gap - 1'b1;
            end
            if (r_state == COMPUTE && w_state_nxt == UNLOAD) r_drain <= 1'b0;
        end
    end

    assign w_rd_top = w_issue ? w_top : '0;
    assign w_rd_bot = w_issue ? w_bot : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{vld: w_issue, top: w_rd_top, bot: w_rd_bot};
            for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign bus.smp_wr_en   = w_load_acc;
    assign bus.smp_wr_addr = w_load_acc ? bitrev3(r_load_cnt) : '0;
    assign bus.bfly_issue  = w_issue;
    assign bus.rd_addr_top = w_rd_top;
    assign bus.rd_addr_bot = w_rd_bot;
    assign bus.tw_idx      = w_issue ? w_tw : '0;
    assign bus.wb_en       = r_pipe[PIPE_LAT-1].vld;
    assign bus.wb_addr_top = r_pipe[PIPE_LAT-1].top;
    assign bus.wb_addr_bot = r_pipe[PIPE_LAT-1].bot;
    assign bus.out_addr    = r_unload_cnt;
    assign bus.busy        = (r_state != LOAD) || (r_load_cnt != '0);
    assign bus.dbg_state   = r_state;

`ifdef FFT8_SEQ_CTRL_SCALE_EN
    assign bus.bfly_scale  = r_pipe[PIPE_LAT-1].vld;
`else
    assign bus.bfly_scale  = 1'b0;
`endif

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Randomized bench for fft8_seq_ctrl against a frame-timeline model; honours FFT8_SEQ_CTRL_SCALE_EN.
module tb_fft8_seq_ctrl;

    localparam int PIPE_LAT = 2;
    localparam int SP       = 4 + PIPE_LAT;
    localparam int W        = 38;
`ifdef FFT8_SEQ_CTRL_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    logic CLK;
    logic RST;

    fft8_seq_ctrl_if bus ();

    fft8_seq_ctrl #(.PIPE_LAT(PIPE_LAT)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks   = 0;
    int n_bad      = 0;
    int cyc        = 0;
    int dut_frames = 0;

    // Model: samples taken, first-issue cycle of the running compute (-1 if none), unload progress.
    int   m_ld        = 0;
    int   m_comp_base = -1;
    int   m_out_cnt   = 0;
    bit   m_unload    = 1'b0;
    bit   m_busy      = 1'b0;
    logic [W-1:0] exp_q[$];

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] brev(input int i);
        return 32'(((i & 1) << 2) | (i & 2) | ((i >> 2) & 1));
    endfunction

    // {top, bot, k} from the DIT span rule.
    function automatic logic [7:0] bfly_of(input int s, input int b);
        int span, pos, top;
        span = 1 << s;
        pos  = b & (span - 1);
        top  = (b >> s) * 2 * span + pos;
        return {3'(top), 3'(top + span), 2'(pos << (2 - s))};
    endfunction

    task automatic model_clear();
        m_ld        = 0;
        m_comp_base = -1;
        m_out_cnt   = 0;
        m_unload    = 1'b0;
        m_busy      = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: compares every output each cycle, then advances the model.
    always @(negedge CLK) begin
        logic         e_rdy, e_acc, e_iss, e_wb;
        int           rel;
        logic [7:0]   bf;
        logic [W-1:0] item;
        if (RST) begin
            model_clear();
        end else begin
            e_rdy = (m_comp_base < 0) && !m_unload;
            e_acc = e_rdy && bus.in_valid;
            check_eq("in_ready", 32'(bus.in_ready), 32'(e_rdy));
            check_eq("smp_wr_en", 32'(bus.smp_wr_en), 32'(e_acc));
            if (e_acc) check_eq("smp_wr_addr", 32'(bus.smp_wr_addr), brev(m_ld));

            e_iss = 1'b0;
            bf    = '0;
            rel   = 0;
            if (m_comp_base >= 0) begin
                rel   = cyc - m_comp_base;
                e_iss = (rel % SP) < 4;
                bf    = bfly_of(rel / SP, rel % SP);
            end
            check_eq("bfly_issue", 32'(bus.bfly_issue), 32'(e_iss));
            if (e_iss) begin
                check_eq("rd_addr_top", 32'(bus.rd_addr_top), 32'(bf[7:5]));
                check_eq("rd_addr_bot", 32'(bus.rd_addr_bot), 32'(bf[4:2]));
                check_eq("tw_idx", 32'(bus.tw_idx), 32'(bf[1:0]));
            end

            e_wb = (exp_q.size() > 0) && (int'(exp_q[0][W-1:6]) == cyc);
            check_eq("wb_en", 32'(bus.wb_en), 32'(e_wb));
            check_eq("bfly_scale", 32'(bus.bfly_scale), 32'(SCALE_ON && e_wb));
            if (e_wb) begin
                item = exp_q.pop_front();
                check_eq("wb_addr_top", 32'(bus.wb_addr_top), 32'(item[5:3]));
                check_eq("wb_addr_bot", 32'(bus.wb_addr_bot), 32'(item[2:0]));
            end
            if (e_iss) exp_q.push_back({32'(cyc + PIPE_LAT), bf[7:2]});

            check_eq("out_valid", 32'(bus.out_valid), 32'(m_unload));
            if (m_unload) check_eq("out_addr", 32'(bus.out_addr), 32'(m_out_cnt));
            check_eq("frame_done", 32'(bus.frame_done), 32'(m_unload && bus.out_ready && m_out_cnt == 7));
            check_eq("busy", 32'(bus.busy), 32'(m_busy));
            if (bus.frame_done) dut_frames++;

            if (e_acc) begin
                m_busy = 1'b1;
                m_ld++;
                if (m_ld == 8) begin
                    m_ld        = 0;
                    m_comp_base = cyc + 1;
                end
            end else if (m_comp_base >= 0 && rel == 3 * SP - 1) begin
                m_comp_base = -1;
                m_unload    = 1'b1;
            end else if (m_unload && bus.out_ready) begin
                m_out_cnt++;
                if (m_out_cnt == 8) begin
                    m_out_cnt = 0;
                    m_unload  = 1'b0;
                    m_busy    = 1'b0;
                end
            end
        end
    end

    // Driver tasks
    task automatic step(input bit v, input bit r);
        @(posedge CLK);
        #1;
        bus.in_valid  = v;
        bus.out_ready = r;
    endtask

    task automatic run_frames(input int n, input int vpct, input int rpct, input string tag);
        int target;
        int guard;
        target = dut_frames + n;
        guard  = 0;
        while (dut_frames < target && guard < 1500) begin
            step($urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct);
            guard++;
        end
        check_eq({"frames_", tag}, 32'(dut_frames >= target), 32'd1);
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, "_in_ready"},    32'(bus.in_ready),    32'd0);
        check_eq({tag, "_smp_wr_en"},   32'(bus.smp_wr_en),   32'd0);
        check_eq({tag, "_smp_wr_addr"}, 32'(bus.smp_wr_addr), 32'd0);
        check_eq({tag, "_bfly_issue"},  32'(bus.bfly_issue),  32'd0);
        check_eq({tag, "_rd_top"},      32'(bus.rd_addr_top), 32'd0);
        check_eq({tag, "_rd_bot"},      32'(bus.rd_addr_bot), 32'd0);
        check_eq({tag, "_tw_idx"},      32'(bus.tw_idx),      32'd0);
        check_eq({tag, "_wb_en"},       32'(bus.wb_en),       32'd0);
        check_eq({tag, "_wb_top"},      32'(bus.wb_addr_top), 32'd0);
        check_eq({tag, "_wb_bot"},      32'(bus.wb_addr_bot), 32'd0);
        check_eq({tag, "_bfly_scale"},  32'(bus.bfly_scale),  32'd0);
        check_eq({tag, "_out_valid"},   32'(bus.out_valid),   32'd0);
        check_eq({tag, "_out_addr"},    32'(bus.out_addr),    32'd0);
        check_eq({tag, "_busy"},        32'(bus.busy),        32'd0);
        check_eq({tag, "_frame_done"},  32'(bus.frame_done),  32'd0);
    endtask

    initial begin
        int guard;
        RST           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge CLK);
        #1;
        check_reset_zero("rst_init");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Back-to-back frame, sink always ready.
        run_frames(1, 100, 100, "b2b");

        // Sink stalls five cycles while out_addr is 3.
        guard = 0;
        while (!(bus.out_valid && bus.out_addr == 3'd3) && guard < 200) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_eq("reach_addr3", 32'(bus.out_addr), 32'd3);
        bus.out_ready = 1'b0;
        repeat (5) begin
            step(1'b1, 1'b0);
            check_eq("stall_addr", 32'(bus.out_addr), 32'd3);
            check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        run_frames(1, 100, 100, "stall_resume");

        // Reset pulse while stage 1 is issuing, with a write-back still in flight.
        guard = 0;
        while (!(m_comp_base >= 0 && cyc - m_comp_base == SP + 1) && guard < 200) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_eq("reach_stage1", 32'(bus.bfly_issue), 32'd1);
        bus.in_valid = 1'b0;
        RST          = 1'b1;
        #1;
        check_reset_zero("rst_mid");
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        RST = 1'b0;
        run_frames(1, 100, 100, "post_rst");

        // Random source gaps and sink back-pressure.
        run_frames(3, 60, 50, "rand");

        repeat (4) step(1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/fft8_seq_ctrl.md
Name: fft8_seq_ctrl

Overview:
- Sequencing controller for the 8-point radix-2 DIT FFT datapath.
- Owns the frame flow: load 8 samples into the sample buffer at bit-reversed addresses, issue 12 butterflies (3 stages x 4), then unload 8 results in natural order.
- Drives buffer addresses, twiddle index for the shared registered complex multiplier, and write-back strobes. Holds no sample data itself.

Parameters:
PIPE_LAT, 2, cycles from bfly_issue to wb_en for the same butterfly (multiplier register + butterfly add register); legal range 1..7
N_PTS, 8, FFT size; fixed at 8, present only for package consistency

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  controller accepts a sample this cycle
smp_wr_en  out  1  write incoming sample to buffer
smp_wr_addr  out  3  bit-reversed load address
bfly_issue  out  1  read top/bot operands and start a butterfly this cycle
rd_addr_top  out  3  top operand address
rd_addr_bot  out  3  bottom operand address (multiplied by twiddle)
tw_idx  out  2  twiddle exponent k; multiplier uses W8^k, Q2.10
wb_en  out  1  write butterfly results back
wb_addr_top  out  3  write-back address for the sum
wb_addr_bot  out  3  write-back address for the difference
bfly_scale  out  1  datapath shifts both butterfly outputs right by 1
out_valid  out  1  result at out_addr valid
out_ready  in  1  downstream accepts result
out_addr  out  3  natural-order read address for unload
busy  out  1  high from first accepted sample until last result accepted
frame_done  out  1  single-cycle pulse on acceptance of the 8th output

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK. All outputs are 0 during reset, including in_ready. State goes to LOAD, all counters are 0, and the write-back pipe is cleared. Reset mid-frame discards the partial frame and produces no wb_en afterwards.
- States: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD:
  - in_ready = 1.
  - On each in_valid&in_ready: smp_wr_en = 1 and smp_wr_addr = bitrev3(load_cnt), i.e. 0,4,2,6,1,5,3,7. load_cnt then increments.
  - busy rises on the first accept. Gaps in in_valid stall the counter.
  - After the 8th accept, go to COMPUTE next cycle with in_ready = 0.
- COMPUTE:
  - Stage s = 0..2, butterfly b = 0..3, one issue per cycle.
  - span = 1<<s; pos = b & (span-1); top = (b>>s)*2*span + pos; bot = top + span; tw_idx = pos<<(2-s).
  - Expected sequences: stage0 tops 0,2,4,6 with k = 0. Stage1 tops 0,1,4,5 with k = 0,2,0,2. Stage2 tops 0..3 with k = 0..3.
  - Write-back: a PIPE_LAT-deep shift register carries {valid, top, bot}. wb_en and wb addresses appear exactly PIPE_LAT cycles after the matching bfly_issue.
  - Hazard gap: the first issue of stage s+1 occurs PIPE_LAT+1 cycles after the last issue of stage s, so stage period = 4+PIPE_LAT cycles. No issue occurs during the gap.
  - After the final stage-2 write-back, go to UNLOAD next cycle.
  - Total COMPUTE duration = 3*(4+PIPE_LAT) cycles counted from the first issue.
- UNLOAD:
  - out_valid = 1, out_addr = unload_cnt (0..7).
  - Advance only on out_valid&out_ready; out_addr is held stable while stalled.
  - On the 8th accept: frame_done pulses, busy falls, state returns to LOAD. in_ready = 1 the following cycle.
- No overlap between frames: samples offered outside LOAD see in_ready = 0.

Optional Feature:
- Macro FFT8_SEQ_CTRL_SCALE_EN.
- Defined: bfly_scale = 1 together with every wb_en, giving a total scaling of 1/8 per frame to prevent growth beyond the multiplier output format.
- Undefined: bfly_scale is tied to 0, with no other change. The port exists in both builds.

Decomposition:
- Package fft8_pkg holds:
  - N_PTS = 8, LOG2N = 3.
  - typedef enum for states {LOAD, COMPUTE, UNLOAD}.
  - typedef for the write-back pipe entry.
  - function bitrev3.
- One sub-module, fft8_addr_gen: combinational mapping (stage, b) -> (top, bot, tw_idx). It is instantiated once and reused by the pipe.

Test Plan:
- Back-to-back 8 samples, out_ready = 1, PIPE_LAT = 2 -> smp_wr_addr 0,4,2,6,1,5,3,7. First bfly_issue the cycle after LOAD ends. 12 issues over 18 cycles. out_addr 0..7. frame_done pulses once.
- Check address/twiddle sequence -> stage2 issues (top,bot,k) = (0,4,0),(1,5,1),(2,6,2),(3,7,3). Each wb_en is exactly 2 cycles after its issue, with matching addresses.
- Stage gap -> with PIPE_LAT = 3, stage0's last issue at cycle t puts stage1's first issue at t+4. No issue in t+1..t+3.
- out_ready low for 5 cycles at out_addr = 3 -> out_addr holds 3 and out_valid stays 1. Resume gives 4..7. busy falls with frame_done.
- RST pulse during stage1 -> all outputs 0 immediately. No wb_en afterwards. in_ready = 1 after release. A fresh frame completes normally.
- Build with FFT8_SEQ_CTRL_SCALE_EN -> bfly_scale equals wb_en on all 12 write-backs. Without the macro, bfly_scale is always 0.
